// File: rtl/pixel_write_buffer.sv
// Pixel write buffer: queues {frame, index, colour} pixels from the core and drains
// them as single-beat 32-bit Avalon-MM writes into the selected SDRAM frame buffer.
module pixel_write_buffer #(
  parameter int                           MASTER_ADDRESSWIDTH = 21,
  parameter int                           DATAWIDTH           = 32,
  parameter int                           DEPTH               = 8,
  parameter logic [MASTER_ADDRESSWIDTH-1:0] FRAME0_BASE       = 21'h000000,
  parameter logic [MASTER_ADDRESSWIDTH-1:0] FRAME1_BASE       = 21'h100000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pix_valid,
  input  logic [18:0]                    pix_address,
  input  logic [15:0]                    pix_color,
  input  logic                           pix_frame,
  output logic                           pix_ready,
  output logic                           busy,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic [3:0]                     master_byteenable,
  output logic                           master_write,
  input  logic                           master_waitrequest
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t state, state_next;

  logic [35:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, count_nz;

  logic [35:0]                    head;
  logic                           head_frame;
  logic [18:0]                    head_index;
  logic [15:0]                    head_color;
  logic [19:0]                    head_offset;
  logic [MASTER_ADDRESSWIDTH-1:0] head_base;

  // Ready looks only at the registered count, so a full FIFO stays not-ready
  // for the whole cycle even when the FSM pops in that same cycle.
  assign pix_ready = (count != (AW+1)'(DEPTH));
  assign count_nz  = (count != '0);
  assign push      = pix_valid & pix_ready;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count_nz) begin
          pop        = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (!master_waitrequest) begin
          if (count_nz) pop = 1'b1;
          else          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of each other; a blocking = would create ordering bugs.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are valid, and a reset port would block RAM inference.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pix_frame, pix_address, pix_color};
  end

  assign head        = mem[rd_ptr];
  assign head_frame  = head[35];
  assign head_index  = head[34:16];
  assign head_color  = head[15:0];
  assign head_offset = {head_index[18:1], 2'b00};
  assign head_base   = head_frame ? FRAME1_BASE : FRAME0_BASE;

  // Output registers only change when an entry is loaded, which keeps them
  // stable across waitrequest stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      master_address    <= '0;
      master_writedata  <= '0;
      master_byteenable <= '0;
    end else if (pop) begin
      master_address    <= head_base + MASTER_ADDRESSWIDTH'(head_offset);
      master_writedata  <= {head_color, head_color};
      master_byteenable <= head_index[0] ? 4'b1100 : 4'b0011;
    end
  end

  assign master_write = (state == WRITE);
  assign busy         = count_nz | (state == WRITE);

endmodule
